// File: rtl/tt_uart_pkg.sv
// Shared types and sizing helpers for the UART receive/transmit stages.
package tt_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int DATA_W      = 8;
   localparam int CPB_MAX     = 4095;
   localparam int TIMER_W_MAX = $clog2(CPB_MAX);

   // Bit-timer width for a given clocks-per-bit; never narrower than 1.
   function automatic int timer_w(input int cpb);
      return (cpb < 2) ? 1 : $clog2(cpb);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable down-counter: tick while enabled at zero, then wraps to RELOAD.
module uart_bit_timer #(
   parameter int          W      = 7,
   parameter logic [W-1:0] RELOAD = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tick
);

   logic [W-1:0] count_reg;

   assign tick = en && (count_reg == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en) begin
         if (count_reg == '0)
            count_reg <= RELOAD;
         else
            count_reg <= count_reg - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_stage.sv
// UART receiver (8N1, or 8E1 when UART_PARITY_EN is defined) with a
// one-entry valid/ready holding register and single-cycle error pulses.
module uart_rx_stage
   import tt_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rxd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun,
   output logic              parity_err
);

   localparam int            TW     = timer_w(CLKS_PER_BIT);
   localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF   = TW'(CLKS_PER_BIT / 2 - 1);

   logic              sync1_reg;
   logic              rxs_reg;
   rx_state_t         state_reg;
   logic [2:0]        bit_idx_reg;
   logic [DATA_W-1:0] shreg_reg;
   logic [DATA_W-1:0] data_reg;
   logic              valid_reg;
   logic              frame_err_reg;
   logic              overrun_reg;
   logic              tick;
   logic              timer_load;
   logic              byte_ok;

`ifdef UART_PARITY_EN
   logic parity_err_reg;
   logic par_bad_reg;
   assign parity_err = parity_err_reg;
   assign byte_ok    = !par_bad_reg;
`else
   assign parity_err = 1'b0;
   assign byte_ok    = 1'b1;
`endif

   // Start edge aligns the timer to the middle of the start bit.
   assign timer_load = (state_reg == IDLE) && !rxs_reg;

   uart_bit_timer #(
      .W      (TW),
      .RELOAD (RELOAD)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (HALF),
      .en       (state_reg != IDLE),
      .tick     (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         rxs_reg   <= 1'b1;
      end else begin
         sync1_reg <= rxd;
         rxs_reg   <= sync1_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         bit_idx_reg    <= '0;
         shreg_reg      <= '0;
         data_reg       <= '0;
         valid_reg      <= 1'b0;
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
`ifdef UART_PARITY_EN
         parity_err_reg <= 1'b0;
         par_bad_reg    <= 1'b0;
`endif
      end else begin
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
`ifdef UART_PARITY_EN
         parity_err_reg <= 1'b0;
`endif
         if (valid_reg && out_ready)
            valid_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (!rxs_reg)
                  state_reg <= START;
            end
            START: begin
               if (tick) begin
                  if (rxs_reg) begin
                     state_reg <= IDLE;
                  end else begin
                     state_reg   <= DATA;
                     bit_idx_reg <= '0;
`ifdef UART_PARITY_EN
                     par_bad_reg <= 1'b0;
`endif
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shreg_reg <= {rxs_reg, shreg_reg[DATA_W-1:1]};
                  if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                     state_reg <= PARITY;
`else
                     state_reg <= STOP;
`endif
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (tick) begin
                  state_reg <= STOP;
                  if (rxs_reg != ^shreg_reg) begin
                     parity_err_reg <= 1'b1;
                     par_bad_reg    <= 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  state_reg <= IDLE;
                  if (!rxs_reg) begin
                     frame_err_reg <= 1'b1;
                  end else if (byte_ok) begin
                     // A same-cycle handshake frees the slot for the new byte.
                     if (!valid_reg || out_ready) begin
                        data_reg  <= shreg_reg;
                        valid_reg <= 1'b1;
                     end else begin
                        overrun_reg <= 1'b1;
                     end
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_data  = data_reg;
   assign out_valid = valid_reg;
   assign busy      = (state_reg != IDLE);
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_stage.sv
// Directed bench for uart_rx_stage at 4 clocks per bit.
module tb_uart_rx_stage;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_valid;
   logic       busy;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int n_cmp  = 0;
   int n_fail = 0;

   // Event counters, sampled on the falling edge.
   int        fe_cnt = 0;
   int        ov_cnt = 0;
   int        pe_cnt = 0;
   int        vld_cnt = 0;
   logic [7:0] rx_q[$];

   uart_rx_stage #(.CLKS_PER_BIT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err)  fe_cnt  <= fe_cnt + 1;
         if (overrun)    ov_cnt  <= ov_cnt + 1;
         if (parity_err) pe_cnt  <= pe_cnt + 1;
         if (out_valid)  vld_cnt <= vld_cnt + 1;
         if (out_valid && out_ready) rx_q.push_back(out_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put_bit(input logic b);
      rxd = b;
      cyc(4);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
      put_bit(1'b0);
      for (int i = 0; i < 8; i++) put_bit(d[i]);
`ifdef UART_PARITY_EN
      put_bit(par_v);
`endif
      put_bit(stop_v);
      rxd = 1'b1;
      $display("sent byte %02h stop=%0b par=%0b", d, stop_v, par_v);
   endtask

   int fe0, ov0, pe0, vl0, q0;

   initial begin
      // Reset state
      cyc(3);
      check("rst_data",  out_data,   8'h00);
      check("rst_valid", out_valid,  1'b0);
      check("rst_busy",  busy,       1'b0);
      check("rst_ferr",  frame_err,  1'b0);
      check("rst_ovr",   overrun,    1'b0);
      check("rst_perr",  parity_err, 1'b0);
      rst = 1'b0;
      cyc(4);

      // 1: single byte, consumer always ready
      fe0 = fe_cnt; ov0 = ov_cnt; vl0 = vld_cnt; q0 = rx_q.size();
      send_frame(8'hA5, 1'b1, ^8'hA5);
      cyc(6);
      check("t1_count",  rx_q.size() - q0, 1);
      check("t1_data",   (rx_q.size() > q0) ? rx_q[$] : 8'hxx, 8'hA5);
      check("t1_vcycles", vld_cnt - vl0, 1);
      check("t1_ferr",   fe_cnt - fe0, 0);
      check("t1_ovr",    ov_cnt - ov0, 0);

      // 2: two frames back-to-back while consumer stalls
      out_ready = 1'b0;
      fe0 = fe_cnt; ov0 = ov_cnt; q0 = rx_q.size();
      send_frame(8'h3C, 1'b1, ^8'h3C);
      send_frame(8'hC3, 1'b1, ^8'hC3);
      cyc(6);
      check("t2_ovr",    ov_cnt - ov0, 1);
      check("t2_valid",  out_valid, 1'b1);
      check("t2_held",   out_data, 8'h3C);
      check("t2_ferr",   fe_cnt - fe0, 0);
      out_ready = 1'b1;
      cyc(4);
      check("t2_count",  rx_q.size() - q0, 1);
      check("t2_data",   (rx_q.size() > q0) ? rx_q[$] : 8'hxx, 8'h3C);
      check("t2_vdrop",  out_valid, 1'b0);

      // 3: stop bit low, then a clean frame
      fe0 = fe_cnt; ov0 = ov_cnt; q0 = rx_q.size();
      send_frame(8'h55, 1'b0, ^8'h55);
      cyc(10);
      check("t3_ferr",   fe_cnt - fe0, 1);
      check("t3_nobyte", rx_q.size() - q0, 0);
      check("t3_valid",  out_valid, 1'b0);
      check("t3_ovr",    ov_cnt - ov0, 0);
      send_frame(8'h01, 1'b1, ^8'h01);
      cyc(6);
      check("t3_next",   (rx_q.size() > q0) ? rx_q[$] : 8'hxx, 8'h01);
      check("t3_ferr2",  fe_cnt - fe0, 1);

      // 4: one-clock low glitch while idle
      fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; q0 = rx_q.size();
      rxd = 1'b0;
      cyc(1);
      rxd = 1'b1;
      cyc(2);
      check("t4_busy_hi", busy, 1'b1);
      cyc(4);
      check("t4_busy_lo", busy, 1'b0);
      check("t4_nobyte", rx_q.size() - q0, 0);
      check("t4_flags",  (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

      // 5: reset during data bit 4 of 0xFF
      put_bit(1'b0);
      for (int i = 0; i < 4; i++) put_bit(1'b1);
      rxd = 1'b1;
      cyc(2);
      check("t5_busy_pre", busy, 1'b1);
      rst = 1'b1;
      cyc(1);
      check("t5_busy",   busy, 1'b0);
      check("t5_valid",  out_valid, 1'b0);
      check("t5_data",   out_data, 8'h00);
      check("t5_pulses", {frame_err, overrun, parity_err}, 3'b000);
      rst = 1'b0;
      cyc(10);
      q0 = rx_q.size();
      send_frame(8'h81, 1'b1, ^8'h81);
      cyc(6);
      check("t5_count",  rx_q.size() - q0, 1);
      check("t5_next",   (rx_q.size() > q0) ? rx_q[$] : 8'hxx, 8'h81);

`ifdef UART_PARITY_EN
      // 6: parity bit wrong, then right (0x07 has odd weight, even parity = 1)
      pe0 = pe_cnt; q0 = rx_q.size();
      send_frame(8'h07, 1'b1, 1'b0);
      cyc(6);
      check("t6_perr",   pe_cnt - pe0, 1);
      check("t6_nobyte", rx_q.size() - q0, 0);
      send_frame(8'h07, 1'b1, 1'b1);
      cyc(6);
      check("t6_perr2",  pe_cnt - pe0, 1);
      check("t6_data",   (rx_q.size() > q0) ? rx_q[$] : 8'hxx, 8'h07);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
